// File: rtl/maze_pkg.sv
// Shared types and helpers for the depth-first maze solver.
// Holds the move-direction and FSM-state encodings plus the neighbour step function.
package maze_pkg;

    localparam int MAZE_DIM = 16;
    localparam int COORD_W  = 4;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        START  = 4'd1,
        MARK   = 4'd2,
        PROBE  = 4'd3,
        MOVE   = 4'd4,
        BACK   = 4'd5,
        DONE   = 4'd6,
        FAIL   = 4'd7,
        REPLAY = 4'd8
    } state_t;

    // Result of stepping one cell: ok=0 when the step leaves the grid.
    typedef struct packed {
        logic               ok;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } step_t;

    // Neighbour of (x,y) in direction dir, with explicit edge checks (no wrap-around).
    function automatic step_t step(input logic [COORD_W-1:0] x,
                                   input logic [COORD_W-1:0] y,
                                   input dir_t               dir);
        step_t s;
        s.x  = x;
        s.y  = y;
        s.ok = 1'b0;
        unique case (dir)
            DIR_RIGHT: begin
                s.ok = (x != COORD_W'(MAZE_DIM - 1));
                s.x  = x + COORD_W'(1);
            end
            DIR_DOWN: begin
                s.ok = (y != COORD_W'(MAZE_DIM - 1));
                s.y  = y + COORD_W'(1);
            end
            DIR_LEFT: begin
                s.ok = (x != '0);
                s.x  = x - COORD_W'(1);
            end
            DIR_UP: begin
                s.ok = (y != '0);
                s.y  = y - COORD_W'(1);
            end
            default: s.ok = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/maze_dir_stack.sv
// Direction stack for the maze solver: LIFO of 2-bit moves with a
// combinational top-of-stack view and an indexed read port for path replay.
module maze_dir_stack
    import maze_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  dir_t          push_dir,
    input  logic          pop,
    output dir_t          top_dir,
    input  logic [CW-1:0] rd_idx,
    output dir_t          rd_dir,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dir_t          mem_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          wr_en;
    logic [AW-1:0] wr_idx;

    assign count   = count_q;
    assign top_dir = mem_q[AW'(count_q - CW'(1))];
    assign rd_dir  = mem_q[AW'(rd_idx)];

    // Pointer update: clear wins, pushes are dropped when full, pops when empty.
    always_comb begin
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = AW'(count_q);
        if (clear) begin
            count_d = '0;
        end else if (push && (count_q != CW'(DEPTH))) begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
        end else if (pop && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DIR_RIGHT;
            end
        end else begin
            count_q <= count_d;
            if (wr_en) begin
                mem_q[wr_idx] <= push_dir;
            end
        end
    end

endmodule

// File: rtl/maze_solver.sv
// Depth-first maze solver driving a 16x16 cell memory, with path replay.
// Optional build macro MAZE_SOLVER_CYCLES_EN adds a saturating solve-cycle counter output.
module maze_solver
    import maze_pkg::*;
#(
    parameter int GOAL_X      = 15,
    parameter int GOAL_Y      = 15,
    parameter int STACK_DEPTH = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    output logic               RD,
    output logic               WR,
    output logic               D_in,
    input  logic               D_out,
    output logic               busy,
    output logic               done,
    output logic               fail,
    input  logic               show,
    output logic               move_valid,
    output logic [1:0]         move_dir,
    output logic               move_last
`ifdef MAZE_SOLVER_CYCLES_EN
    ,
    output logic [15:0]        cycles
`endif
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    state_t              state_q, state_d;
    logic [COORD_W-1:0]  pos_x_q, pos_x_d;
    logic [COORD_W-1:0]  pos_y_q, pos_y_d;
    logic [2:0]          d_q, d_d;
    logic [SP_W-1:0]     ridx_q, ridx_d;

    logic                stk_clear, stk_push, stk_pop;
    dir_t                top_dir, rd_dir;
    logic [SP_W-1:0]     sp;
    step_t               nbr, back;
    logic                at_goal, start_acc;

    maze_dir_stack #(
        .DEPTH (STACK_DEPTH),
        .CW    (SP_W)
    ) u_stack (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (stk_clear),
        .push     (stk_push),
        .push_dir (dir_t'(d_q[1:0])),
        .pop      (stk_pop),
        .top_dir  (top_dir),
        .rd_idx   (ridx_q),
        .rd_dir   (rd_dir),
        .count    (sp)
    );

    // Forward neighbour for the current try-direction; reverse step for backtracking.
    assign nbr       = step(pos_x_q, pos_y_q, dir_t'(d_q[1:0]));
    assign back      = step(pos_x_q, pos_y_q, dir_t'(top_dir ^ 2'd2));
    assign at_goal   = (pos_x_q == COORD_W'(GOAL_X)) && (pos_y_q == COORD_W'(GOAL_Y));
    assign start_acc = start && (state_q == IDLE || state_q == DONE || state_q == FAIL);

    assign busy = (state_q == START) || (state_q == MARK) || (state_q == PROBE) ||
                  (state_q == MOVE)  || (state_q == BACK);
    assign done = (state_q == DONE);
    assign fail = (state_q == FAIL);
    assign D_in = WR;

    // Next-state, datapath updates and memory/replay outputs.
    always_comb begin
        state_d    = state_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        d_d        = d_q;
        ridx_d     = ridx_q;
        stk_clear  = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        X          = pos_x_q;
        Y          = pos_y_q;
        RD         = 1'b0;
        WR         = 1'b0;
        move_valid = 1'b0;
        move_dir   = 2'd0;
        move_last  = 1'b0;
        unique case (state_q)
            IDLE, DONE, FAIL: begin
                if (start_acc) begin
                    pos_x_d   = '0;
                    pos_y_d   = '0;
                    d_d       = '0;
                    stk_clear = 1'b1;
                    state_d   = START;
                end else if (state_q == DONE && show && sp != '0) begin
                    ridx_d  = '0;
                    state_d = REPLAY;
                end
            end
            START: begin
                RD      = 1'b1;
                state_d = D_out ? FAIL : MARK;
            end
            MARK: begin
                WR = 1'b1;
                if (at_goal) begin
                    state_d = DONE;
                end else begin
                    d_d     = '0;
                    state_d = PROBE;
                end
            end
            PROBE: begin
                if (d_q[2]) begin
                    state_d = BACK;
                end else begin
                    // Off-grid neighbours count as walls and are never read.
                    if (nbr.ok) begin
                        X  = nbr.x;
                        Y  = nbr.y;
                        RD = 1'b1;
                    end
                    if (!nbr.ok || D_out) begin
                        d_d = d_q + 3'd1;
                    end else if (sp == SP_FULL) begin
                        state_d = FAIL;
                    end else begin
                        stk_push = 1'b1;
                        state_d  = MOVE;
                    end
                end
            end
            MOVE: begin
                pos_x_d = nbr.x;
                pos_y_d = nbr.y;
                state_d = MARK;
            end
            BACK: begin
                // A stack entry that would step off-grid can only mean corruption.
                if (sp == '0 || !back.ok) begin
                    state_d = FAIL;
                end else begin
                    stk_pop = 1'b1;
                    pos_x_d = back.x;
                    pos_y_d = back.y;
                    d_d     = {1'b0, top_dir} + 3'd1;
                    state_d = PROBE;
                end
            end
            REPLAY: begin
                move_valid = 1'b1;
                move_dir   = rd_dir;
                ridx_d     = ridx_q + SP_W'(1);
                if (ridx_q == sp - SP_W'(1)) begin
                    move_last = 1'b1;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pos_x_q <= '0;
            pos_y_q <= '0;
            d_q     <= '0;
            ridx_q  <= '0;
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            d_q     <= d_d;
            ridx_q  <= ridx_d;
        end
    end

`ifdef MAZE_SOLVER_CYCLES_EN
    logic [15:0] cycles_q, cycles_d;

    assign cycles = cycles_q;

    // Solve-time counter: cleared on accepted start, saturating while busy.
    always_comb begin
        cycles_d = cycles_q;
        if (start_acc) begin
            cycles_d = '0;
        end else if (busy && cycles_q != 16'hFFFF) begin
            cycles_d = cycles_q + 16'd1;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end
`endif

endmodule

// File: tb/tb_maze_solver.sv
// Self-checking bench for maze_solver: a cell-memory model plus a plain
// depth-first reference search that predicts outcome, path and final marks.
module tb_maze_solver;

    localparam int GX = 15;
    localparam int GY = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       show = 1'b0;
    logic [3:0] X, Y;
    logic       RD, WR, D_in, D_out;
    logic       busy, done, fail;
    logic       move_valid, move_last;
    logic [1:0] move_dir;
`ifdef MAZE_SOLVER_CYCLES_EN
    logic [15:0] cycles;
`endif

    int checks = 0;
    int errors = 0;

    bit mem [16][16];       // [y][x], the maze memory seen by the DUT
    bit img [16][16];       // map to load
    bit load_req = 1'b0;
    int wr_total = 0;

    int exp_path [$];
    int got_path [$];
    bit exp_ok;
    bit exp_grid [16][16];

    always #5 clk = ~clk;

    maze_solver #(
        .GOAL_X      (GX),
        .GOAL_Y      (GY),
        .STACK_DEPTH (256)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .X          (X),
        .Y          (Y),
        .RD         (RD),
        .WR         (WR),
        .D_in       (D_in),
        .D_out      (D_out),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .show       (show),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_last  (move_last)
`ifdef MAZE_SOLVER_CYCLES_EN
        ,
        .cycles     (cycles)
`endif
    );

    assign D_out = RD ? mem[Y][X] : 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            mem <= img;
        end else if (WR) begin
            mem[Y][X] <= D_in;
            wr_total  <= wr_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: textbook DFS trying right, down, left, up; path kept as a list of moves.
    task automatic model_solve();
        int x, y, d, p, nx, ny;
        int dx [4] = '{1, 0, -1, 0};
        int dy [4] = '{0, 1, 0, -1};
        exp_grid = img;
        exp_path.delete();
        exp_ok = 1'b0;
        if (exp_grid[0][0]) return;
        x = 0; y = 0; d = 0;
        exp_grid[0][0] = 1'b1;
        if (GX == 0 && GY == 0) begin
            exp_ok = 1'b1;
            return;
        end
        while (1) begin
            if (d == 4) begin
                if (exp_path.size() == 0) return;
                p = exp_path.pop_back();
                x = x - dx[p];
                y = y - dy[p];
                d = p + 1;
            end else begin
                nx = x + dx[d];
                ny = y + dy[d];
                if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && !exp_grid[ny][nx]) begin
                    exp_path.push_back(d);
                    x = nx; y = ny;
                    exp_grid[y][x] = 1'b1;
                    if (x == GX && y == GY) begin
                        exp_ok = 1'b1;
                        return;
                    end
                    d = 0;
                end else begin
                    d = d + 1;
                end
            end
        end
    endtask

    task automatic clear_img(input bit v);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                img[y][x] = v;
    endtask

    task automatic load_map();
        @(posedge clk); #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
    endtask

    task automatic run_solve(input int poke, output int cyc, output bit to, output bit busy_first);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        to = 1'b1; cyc = 0; busy_first = 1'b0;
        for (int c = 1; c <= 8000; c++) begin
            @(negedge clk);
            if (c == 1) busy_first = busy;
            if (c == poke) start = 1'b1;
            if (c == poke + 1) start = 1'b0;
            if (done || fail) begin
                cyc = c; to = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic do_replay(output int nlast, output int lastpos, output bit to);
        got_path.delete(); nlast = 0; lastpos = -1; to = 1'b1;
        @(posedge clk); #1 show = 1'b1;
        @(posedge clk); #1 show = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!move_valid) begin
                to = 1'b0;
                break;
            end
            got_path.push_back(int'(move_dir));
            if (move_last) begin
                nlast++;
                lastpos = got_path.size();
            end
        end
    endtask

    task automatic solve_and_check(input string tag, input int poke, output int cyc, output int wrs);
        bit to, bf, rto;
        int mism, nlast, lastpos, nv, n;
        model_solve();
        load_map();
        wrs = wr_total;
        run_solve(poke, cyc, to, bf);
        wrs = wr_total - wrs;
        chk({tag, ":timeout"}, to, 0);
        chk({tag, ":busy_after_start"}, bf, 1);
        chk({tag, ":done"}, done, exp_ok);
        chk({tag, ":fail"}, fail, !exp_ok);
        chk({tag, ":busy_end"}, busy, 0);
        mism = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                if (mem[y][x] != exp_grid[y][x]) mism++;
        chk({tag, ":grid_mismatches"}, mism, 0);
        if (exp_ok) begin
            do_replay(nlast, lastpos, rto);
            chk({tag, ":replay_timeout"}, rto, 0);
            chk({tag, ":path_len"}, got_path.size(), exp_path.size());
            chk({tag, ":last_count"}, nlast, 1);
            chk({tag, ":last_pos"}, lastpos, exp_path.size());
            n = (got_path.size() < exp_path.size()) ? got_path.size() : exp_path.size();
            mism = 0;
            for (int i = 0; i < n; i++)
                if (got_path[i] != exp_path[i]) mism++;
            chk({tag, ":path_dirs"}, mism, 0);
            chk({tag, ":done_after_replay"}, done, 1);
        end else begin
            @(posedge clk); #1 show = 1'b1;
            @(posedge clk); #1 show = 1'b0;
            nv = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (move_valid) nv++;
            end
            chk({tag, ":show_in_fail_moves"}, nv, 0);
            chk({tag, ":fail_holds"}, fail, 1);
        end
    endtask

    initial begin
        int cyc, wrs, rights, found;
        bit shape;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst:busy", busy, 0);
        chk("rst:done", done, 0);
        chk("rst:fail", fail, 0);
        chk("rst:RD", RD, 0);
        chk("rst:WR", WR, 0);
        chk("rst:D_in", D_in, 0);
        chk("rst:XY", {X, Y}, 0);
        chk("rst:move", {move_valid, move_last, move_dir}, 0);
`ifdef MAZE_SOLVER_CYCLES_EN
        chk("rst:cycles", cycles, 0);
`endif
        @(negedge clk); rst_n = 1'b1;

        // All-open map, with a start pulse mid-solve that must be ignored
        clear_img(1'b0);
        solve_and_check("open", 4, cyc, wrs);
        chk("open:len30", got_path.size(), 30);
        shape = (got_path.size() == 30);
        for (int i = 0; i < got_path.size() && i < 30; i++)
            if (got_path[i] != ((i < 15) ? 0 : 1)) shape = 1'b0;
        chk("open:15R_15D", shape, 1);
        chk("open:writes", wrs, 31);
`ifdef MAZE_SOLVER_CYCLES_EN
        chk("open:cycles", cycles, 107);
        repeat (5) @(negedge clk);
        chk("open:cycles_stable", cycles, 107);
`endif

        // Start cell walled
        clear_img(1'b0);
        img[0][0] = 1'b1;
        solve_and_check("wall00", 0, cyc, wrs);
        chk("wall00:fail_latency", cyc, 2);
        chk("wall00:no_writes", wrs, 0);

        // Goal sealed off: full exhaustion
        clear_img(1'b0);
        img[15][14] = 1'b1;
        img[14][15] = 1'b1;
        solve_and_check("sealed", 0, cyc, wrs);
        chk("sealed:writes", wrs, 253);

        // Dead-end branch along row 0, real path down column 0 then along row 15
        clear_img(1'b1);
        for (int i = 0; i <= 5; i++) img[0][i] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            img[i][0]  = 1'b0;
            img[15][i] = 1'b0;
        end
        solve_and_check("deadend", 0, cyc, wrs);
        rights = 0;
        for (int i = 0; i < got_path.size() && i < 15; i++)
            if (got_path[i] == 0) rights++;
        chk("deadend:no_row0_rights", rights, 0);
        chk("deadend:len30", got_path.size(), 30);

        // Asynchronous reset while probing (2,0)->(3,0)
        clear_img(1'b0);
        load_map();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (RD && X == 4'd3 && Y == 4'd0) begin
                found = 1;
                break;
            end
        end
        chk("midrst:reached_probe", found, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst:busy", busy, 0);
        chk("midrst:RD", RD, 0);
        chk("midrst:WR", WR, 0);
        chk("midrst:XY", {X, Y}, 0);
        chk("midrst:done_fail", {done, fail}, 0);
`ifdef MAZE_SOLVER_CYCLES_EN
        chk("midrst:cycles", cycles, 0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        clear_img(1'b0);
        solve_and_check("after_rst", 0, cyc, wrs);

        // Random mazes
        for (int t = 0; t < 6; t++) begin
            for (int y = 0; y < 16; y++)
                for (int x = 0; x < 16; x++)
                    img[y][x] = ($urandom_range(0, 99) < 30);
            img[0][0] = 1'b0;
            img[GY][GX] = 1'b0;
            solve_and_check($sformatf("rand%0d", t), 0, cyc, wrs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
